// File: rtl/separador_out.sv
// -----------------------------------------------------------------------------
// separador_out
//
// Output-side block splitter for the hashing datapath. Accepts one 16-byte
// block per valid/ready handshake, registers its upper 12 bytes as the entry
// field and its lower 4 bytes as the nonce field, and streams the whole block
// out one byte per beat under valid/ready flow control.
//
// Optional feature macro: SEPARADOR_CNT_EN
//   When defined, the blocks_done port exists and counts blocks whose final
//   (out_last) beat completed. It wraps from 0xFFFF to 0x0000.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset (0 = reset)
//   in_valid      in   block_in holds a valid block
//   in_ready      out  a block can be accepted this cycle
//   block_in      in   128-bit block, byte k = block_in[127-8k -: 8]
//   entry_12      out  registered entry field (block[127:32])
//   nonce         out  registered nonce field (block[31:0])
//   split_valid   out  one-cycle pulse after entry_12/nonce update
//   out_valid     out  out_byte is valid
//   out_ready     in   consumer takes out_byte this cycle
//   out_byte      out  current stream byte
//   out_is_nonce  out  current byte belongs to the nonce field
//   out_last      out  current byte is the final byte of the block
//   blocks_done   out  completed-block counter (SEPARADOR_CNT_EN only)
// -----------------------------------------------------------------------------
module separador_out #(
  parameter int ENTRY_BYTES = 12,
  parameter int NONCE_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [8*(ENTRY_BYTES+NONCE_BYTES)-1:0] block_in,
  output logic [8*ENTRY_BYTES-1:0]      entry_12,
  output logic [8*NONCE_BYTES-1:0]      nonce,
  output logic                          split_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_byte,
  output logic                          out_is_nonce,
  output logic                          out_last
`ifdef SEPARADOR_CNT_EN
  ,
  output logic [15:0]                   blocks_done
`endif
);

  localparam int BLOCK_BYTES = ENTRY_BYTES + NONCE_BYTES;
  localparam int BLOCK_W     = 8 * BLOCK_BYTES;
  localparam int NONCE_W     = 8 * NONCE_BYTES;

  localparam logic [3:0] LAST_IDX    = 4'(BLOCK_BYTES - 1);
  localparam logic [3:0] NONCE_START = 4'(ENTRY_BYTES);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [3:0]           idx;
  logic [BLOCK_W-1:0]   hold;
  logic [BLOCK_W-1:0]   hold_shifted;

  logic                 accept;
  logic                 beat_done;
  logic                 last_beat;

  // Handshake qualifiers shared by the FSM and the datapath.
  assign accept    = in_valid && in_ready;
  assign beat_done = out_valid && out_ready;
  assign last_beat = beat_done && (idx == LAST_IDX);

  // in_ready also opens on the final beat of a stream so the next block can
  // follow with no bubble. It is forced low while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      if (state == IDLE) begin
        in_ready = 1'b1;
      end else if ((idx == LAST_IDX) && out_ready) begin
        in_ready = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A new accept on the final beat keeps us in STREAM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (last_beat) begin
          state_next = accept ? STREAM : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: hold buffer, split fields, beat index and the
  // split_valid pulse. idx is reloaded on accept and otherwise only advances
  // on completed beats, so a stall freezes the current byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold        <= '0;
      entry_12    <= '0;
      nonce       <= '0;
      idx         <= '0;
      split_valid <= 1'b0;
    end else begin
      split_valid <= accept;
      if (accept) begin
        hold     <= block_in;
        entry_12 <= block_in[BLOCK_W-1:NONCE_W];
        nonce    <= block_in[NONCE_W-1:0];
        idx      <= '0;
      end else if (last_beat) begin
        idx <= '0;
      end else if (beat_done) begin
        idx <= idx + 4'd1;
      end
    end
  end

`ifdef SEPARADOR_CNT_EN
  // Completed-block counter; natural 16-bit wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blocks_done <= '0;
    end else if (last_beat) begin
      blocks_done <= blocks_done + 16'd1;
    end
  end
`endif

  // Byte 0 sits in the top byte of the block, so shifting left by idx bytes
  // brings the current byte to the top.
  assign hold_shifted = hold << {idx, 3'b000};

  // Beat outputs are only meaningful in STREAM; they read zero otherwise so
  // no stale byte is ever presented.
  always_comb begin
    out_valid    = 1'b0;
    out_byte     = 8'h00;
    out_is_nonce = 1'b0;
    out_last     = 1'b0;
    if (state == STREAM) begin
      out_valid    = 1'b1;
      out_byte     = hold_shifted[BLOCK_W-1 -: 8];
      out_is_nonce = (idx >= NONCE_START);
      out_last     = (idx == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_separador_out.sv
// -----------------------------------------------------------------------------
// tb_separador_out
//
// Self-checking bench for separador_out. A byte-queue reference model tracks
// the bytes still owed to the consumer, the last split fields and the
// completed-block count; every cycle the DUT outputs are compared with it.
// Honours SEPARADOR_CNT_EN to connect and check blocks_done.
// -----------------------------------------------------------------------------
module tb_separador_out;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] block_in = '0;
  logic         in_ready;
  logic [95:0]  entry_12;
  logic [31:0]  nonce;
  logic         split_valid;
  logic         out_valid;
  logic [7:0]   out_byte;
  logic         out_is_nonce;
  logic         out_last;
`ifdef SEPARADOR_CNT_EN
  logic [15:0]  blocks_done;
`endif

  always #5 clk = ~clk;

  separador_out dut (
    .clk          (clk),
    .reset        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .block_in     (block_in),
    .entry_12     (entry_12),
    .nonce        (nonce),
    .split_valid  (split_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_byte     (out_byte),
    .out_is_nonce (out_is_nonce),
    .out_last     (out_last)
`ifdef SEPARADOR_CNT_EN
    ,
    .blocks_done  (blocks_done)
`endif
  );

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state.
  logic [7:0]  mq[$];
  int          mpos = 0;
  logic [95:0] mentry = '0;
  logic [31:0] mnonce = '0;
  bit          msplit = 1'b0;
  logic [15:0] mdone = '0;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit modelReady(input bit r);
    return rst_n && ((mq.size() == 0) || ((mq.size() == 1) && r));
  endfunction

  task automatic modelReset();
    mq.delete();
    mpos   = 0;
    mentry = '0;
    mnonce = '0;
    msplit = 1'b0;
    mdone  = '0;
  endtask

  // Compare the registered/beat outputs against the model.
  task automatic checkState();
    checkOutput("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      checkOutput("out_byte", out_byte, mq[0]);
      checkOutput("out_is_nonce", out_is_nonce, mpos >= 12);
      checkOutput("out_last", out_last, mpos == 15);
    end
    checkOutput("entry_12", entry_12, mentry);
    checkOutput("nonce", nonce, mnonce);
    checkOutput("split_valid", split_valid, msplit);
`ifdef SEPARADOR_CNT_EN
    checkOutput("blocks_done", blocks_done, mdone);
`endif
  endtask

  // Drive one cycle of inputs (called just after a falling edge), check
  // in_ready, advance the model across the rising edge, then check outputs.
  task automatic applyStimulus(input bit v, input logic [127:0] b, input bit r,
                               output bit acc);
    bit expReady;
    in_valid  = v;
    block_in  = b;
    out_ready = r;
    #1;
    expReady = modelReady(r);
    checkOutput("in_ready", in_ready, expReady);
    acc = v && expReady;
    @(posedge clk);
    if ((mq.size() > 0) && r) begin
      void'(mq.pop_front());
      if (mpos == 15) mdone = mdone + 16'd1;
      mpos++;
    end
    if (acc) begin
      mq.delete();
      for (int k = 0; k < 16; k++) mq.push_back(b[127-8*k -: 8]);
      mpos   = 0;
      mentry = b[127:32];
      mnonce = b[31:0];
      msplit = 1'b1;
    end else begin
      msplit = 1'b0;
    end
    @(negedge clk);
    checkState();
  endtask

  initial begin
    logic [127:0] blk;
    logic [127:0] rb;
    bit           acc;
    bit           rv;
    bit           rr;
    bit           held;
    int           sent;

    blk = 128'h000102030405060708090A0B0C0D0E0F;

    // Reset values while reset is held.
    #3;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_byte", out_byte, 8'h00);
    checkOutput("rst_out_last", out_last, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_entry", entry_12, 96'h0);
    checkOutput("rst_nonce", nonce, 32'h0);
    checkOutput("rst_split", split_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single counting block with the consumer always ready.
    $display("[TB] single block");
    applyStimulus(1'b1, blk, 1'b1, acc);
    checkOutput("dir_accept", acc, 1'b1);
    checkOutput("dir_entry", entry_12, 96'h000102030405060708090A0B);
    checkOutput("dir_nonce", nonce, 32'h0C0D0E0F);
    checkOutput("dir_byte0", out_byte, 8'h00);
    for (int c = 0; c < 17; c++) applyStimulus(1'b0, '0, 1'b1, acc);

    // Back-to-back blocks A then B with in_valid held.
    $display("[TB] back-to-back");
    sent = 0;
    for (int c = 0; c < 36; c++) begin
      applyStimulus(sent < 2, (sent == 0) ? {16{8'hAA}} : {16{8'h55}}, 1'b1, acc);
      if (acc) sent++;
      if ((c > 0) && (c < 32)) checkOutput("b2b_no_gap", out_valid, 1'b1);
    end

    // Backpressure at idx 5 and a 0xFF block offered from idx 3.
    $display("[TB] backpressure");
    applyStimulus(1'b1, blk, 1'b1, acc);
    for (int c = 0; c < 36; c++) begin
      applyStimulus(c >= 3, {16{8'hFF}}, !((c >= 5) && (c < 8)), acc);
      if ((c >= 5) && (c < 7)) checkOutput("stall_byte", out_byte, 8'h05);
    end

    // Randomized traffic with a well-behaved sender that holds its block.
    $display("[TB] random");
    held = 1'b0;
    rv   = 1'b0;
    rb   = '0;
    for (int c = 0; c < 400; c++) begin
      if (!held) begin
        rv = ($urandom_range(0, 2) != 0);
        rb = {$urandom, $urandom, $urandom, $urandom};
      end
      rr = ($urandom_range(0, 3) != 0);
      applyStimulus(rv, rb, rr, acc);
      held = rv && !acc;
    end
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, '0, 1'b1, acc);

    // Reset mid-stream at idx 9, then a fresh block from byte 0.
    $display("[TB] mid-stream reset");
    applyStimulus(1'b1, blk, 1'b1, acc);
    for (int c = 0; c < 9; c++) applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("pre_rst_byte", out_byte, 8'h09);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("arst_out_valid", out_valid, 1'b0);
    checkOutput("arst_out_byte", out_byte, 8'h00);
    checkOutput("arst_in_ready", in_ready, 1'b0);
    checkOutput("arst_entry", entry_12, 96'h0);
    checkOutput("arst_nonce", nonce, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 1'b1, acc);
    checkOutput("post_rst_byte0", out_byte, 8'hF0);
    for (int c = 0; c < 17; c++) applyStimulus(1'b0, '0, 1'b1, acc);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/separador_out.md
# separador_out

Inverse of the block concatenator on the output side of the hashing datapath. It accepts one 16-byte block per handshake and splits it into a 12-byte entry field and a 4-byte nonce field. Both fields are registered and presented in parallel. The block is also streamed out one byte per beat, under valid/ready flow control, to the downstream byte-wide consumer.

## Interface
- ENTRY_BYTES, 12, bytes in the entry field (upper part of the block)
- NONCE_BYTES, 4, bytes in the nonce field (lower part of the block)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  block_in is valid
- in_ready  out  1  block can be accepted this cycle
- block_in  in  128  block; byte k = block_in[127-8k -: 8]
- entry_12  out  96  registered entry field = block[127:32]
- nonce  out  32  registered nonce field = block[31:0]
- split_valid  out  1  one-cycle pulse: entry_12/nonce just updated
- out_valid  out  1  out_byte valid
- out_ready  in  1  consumer takes out_byte
- out_byte  out  8  current stream byte
- out_is_nonce  out  1  current byte belongs to nonce field
- out_last  out  1  current byte is byte 15
- blocks_done  out  16  only with SEPARADOR_CNT_EN; see Configuration

## Operation
- Accept: in_valid && in_ready at a rising edge. The block is latched into a 128-bit hold register, entry_12/nonce load, and idx is set to 0.
- FSM states:
  - IDLE -> STREAM on accept.
  - STREAM -> IDLE when the beat with idx==15 completes (out_valid && out_ready) and no new accept occurs.
  - STREAM -> STREAM on the final beat when a new block is accepted in the same cycle.
- in_ready = reset && (IDLE || (STREAM && idx==15 && out_ready)). This is combinational and gives back-to-back blocks with no bubble.
- Beat outputs:
  - out_valid = (state==STREAM).
  - out_byte = hold byte idx; idx 0 = block_in[127:120].
  - out_is_nonce = (idx >= ENTRY_BYTES).
  - out_last = (idx == ENTRY_BYTES+NONCE_BYTES-1).
- idx is a 4-bit counter that increments on each completed beat. It is reloaded to 0 on accept and never wraps inside a block.
- Stall: while out_valid && !out_ready, out_byte, out_is_nonce, out_last and idx hold.
- entry_12 and nonce hold their last value until the next accept; streaming does not disturb them.
- in_valid with in_ready=0: block_in is ignored. The sender must hold it; no data is lost inside this block.

## Timing
- Reset (asynchronous, while reset=0): state=IDLE, idx=0, hold=0.
  - entry_12=0, nonce=0, split_valid=0, out_valid=0, out_byte=0, out_is_nonce=0, out_last=0, in_ready=0, blocks_done=0.
- First cycle after reset release: in_ready=1.
- Accept at edge N:
  - split_valid=1 during cycle N+1 only.
  - out_valid=1 with byte 0 from cycle N+1.
- Full throughput: 16 cycles per block. Byte 15 of block A and byte 0 of block B are on adjacent cycles.
- Reset asserted mid-stream: immediate clear; the partial block is discarded and never resumed.

## Configuration
- SEPARADOR_CNT_EN defined:
  - blocks_done port exists and counts blocks whose out_last beat completed.
  - Wraps 0xFFFF -> 0x0000; cleared by reset.
- SEPARADOR_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release then single block 0x000102…0F, out_ready=1:
  - entry_12=0x000102030405060708090A0B and nonce=0x0C0D0E0F, split_valid pulse at N+1.
  - Bytes 00..0F on 16 consecutive cycles; out_is_nonce high on bytes 0C..0F; out_last on 0F; in_ready back to 1.
- Back-to-back: in_valid held with block A=all 0xAA, then B=all 0x55, out_ready=1:
  - 32 consecutive beats with no gap; B is accepted on A's out_last cycle; split_valid pulses 16 cycles apart.
- Backpressure: drop out_ready at idx 5 for 3 cycles:
  - out_byte=0x05 is held stable with out_valid=1; in_ready stays 0; stream resumes at 0x05.
- Reset asserted at idx 9:
  - All outputs go to 0 asynchronously; after release, a new block streams from byte 0 and no stale byte appears.
- in_valid high while streaming (idx 3, 0xFF block):
  - Block is not accepted until the idx 15 beat; entry_12/nonce unchanged until then.
- With SEPARADOR_CNT_EN, 3 blocks streamed:
  - blocks_done=3; a preset count of 0xFFFF plus one block reads 0x0000.
